// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and helpers for the arbitrating multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the arbitration mode input
//   clog2()              : ceil(log2(v)), usable in parameter defaults
package arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational fixed-priority / round-robin grant selection.
//   req       [N]    : pending requests
//   mode      1      : MODE_FIXED searches from 0, MODE_RR searches from ptr
//   ptr       [SELW] : round-robin search start (always < N)
//   en        1      : grant permitted this cycle
//   grant     [N]    : one-hot grant, or zero
//   grant_idx [SELW] : index of the granted request (0 when none)
//   any       1      : a grant was issued
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  int unsigned     start;
  logic [SELW-1:0] idx;

  // Walk the N candidates from the start point, wrapping mod N, first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    start     = (mode == MODE_RR) ? (32'(ptr) % N) : 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = SELW'((start + k) % N);
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel registered arbitrating multiplexer with valid/ready on
// every input and on the output.
//   clk, rst             : clock, synchronous active-high reset
//   mode                 : 0 fixed priority (lowest index), 1 round-robin
//   in_data  [N*WIDTH]   : channel i at [i*WIDTH +: WIDTH]
//   in_valid [N]         : channel i has data pending
//   in_ready [N]         : one-hot/zero, channel i's data is taken this cycle
//   out_data [WIDTH]     : registered selected data
//   out_sel  [SELW]      : registered index of the supplying channel
//   out_valid            : out_data/out_sel valid
//   out_ready            : downstream accepts this cycle
module arb_mux
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             free;
  logic             arb_en;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  ptr_next;

  // Register can take a word when empty or being drained this cycle;
  // nothing is granted while reset is asserted.
  always_comb begin
    free   = !out_valid_q || out_ready;
    arb_en = free && !rst;
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .mode      (mode),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign in_ready = grant;

  // One-hot AND-OR data select driven by the grant vector.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Explicit wrap so non-power-of-two N never yields an index >= N.
  always_comb begin
    if (grant_idx == SELW'(N - 1)) ptr_next = '0;
    else                           ptr_next = grant_idx + SELW'(1);
  end

  // Output register and pointer next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (free) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = grant_data;
        out_sel_d  = grant_idx;
        if (mode == MODE_RR) ptr_d = ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
